// File: rtl/toggle_period_meter.sv
// Toggle period meter: synchronises an async toggle input,
// times rise-to-rise spacing in clk cycles, hands results out on valid/ready.
module toggle_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             t_in,
  input  logic             en,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             drop_err,
  output logic [7:0]       edge_count,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ovf;

  logic       w_rise;
  logic       w_slot_free;
  logic       w_res_load;
  logic [1:0] w_state_nxt;

  assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign w_slot_free = ~period_valid | period_ready;
  assign w_res_load  = en & (r_state == S_MEASURE) & w_rise;

  // Synchroniser chain plus one delay flop for rise detection
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], t_in};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  // Next-state decode; dropping en wins over a rise
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!en)        w_state_nxt = S_IDLE;
        else if (w_rise) w_state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (!en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, busy, period counter, overflow flag and edge counter
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      busy       <= 1'b0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      edge_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != S_IDLE);
      if (!en) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        unique case (r_state)
          S_ARMED: begin
            if (w_rise) begin
              r_cnt      <= CNT_ONE;
              r_ovf      <= 1'b0;
              edge_count <= edge_count + 8'd1;
            end
          end
          S_MEASURE: begin
            if (w_rise) begin
              r_cnt      <= CNT_ONE;
              r_ovf      <= 1'b0;
              edge_count <= edge_count + 8'd1;
            end else if (r_cnt == CNT_MAX) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end
        endcase
      end
    end
  end

  // Single-entry result slot with sticky drop flag
  always_ff @(posedge clk) begin
    if (clr) begin
      period       <= '0;
      overflow     <= 1'b0;
      period_valid <= 1'b0;
      drop_err     <= 1'b0;
    end else if (w_res_load && w_slot_free) begin
      period       <= r_cnt;
      overflow     <= r_ovf;
      period_valid <= 1'b1;
    end else begin
      if (w_res_load) drop_err <= 1'b1;
      if (period_valid && period_ready) period_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Directed bench for toggle_period_meter:
// a 16-bit and a 4-bit instance share one stimulus stream.
module tb_toggle_period_meter;

  logic clk = 1'b0;
  logic clr;
  logic t_in;
  logic en;
  logic ready;

  logic [15:0] p16;
  logic        v16, o16, d16, b16;
  logic [7:0]  e16;
  logic [3:0]  p4;
  logic        v4, o4, d4, b4;
  logic [7:0]  e4;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int sp;
    bit has;
    int p16;
    bit o16;
    int p4;
    bit o4;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    logic        o;
  } res_t;

  vec_t tbl[7];
  res_t q16[$];
  res_t q4[$];

  always #5 clk = ~clk;

  toggle_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .clr(clr), .t_in(t_in), .en(en),
    .period(p16), .period_valid(v16),
    .period_ready(ready), .overflow(o16),
    .drop_err(d16), .edge_count(e16), .busy(b16)
  );

  toggle_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .clr(clr), .t_in(t_in), .en(en),
    .period(p4), .period_valid(v4),
    .period_ready(ready), .overflow(o4),
    .drop_err(d4), .edge_count(e4), .busy(b4)
  );

  // Record every accepted result
  always @(negedge clk) begin
    if (!clr && v16 && ready) q16.push_back('{p16, o16});
    if (!clr && v4 && ready) q4.push_back('{{12'd0, p4}, o4});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Rise now, next rise exactly p cycles later
  task automatic gap(input int p);
    int h;
    h = p / 2;
    t_in = 1'b1;
    repeat (h) step();
    t_in = 1'b0;
    repeat (p - h) step();
  endtask

  task automatic pop16(input string nm,
                       input int ep, input bit eo);
    res_t r;
    if (q16.size() == 0) begin
      chk({nm, " present"}, 0, 1);
    end else begin
      r = q16.pop_front();
      chk({nm, " period"}, r.p, ep);
      chk({nm, " ovf"}, r.o, eo);
    end
  endtask

  task automatic pop4(input string nm,
                      input int ep, input bit eo);
    res_t r;
    if (q4.size() == 0) begin
      chk({nm, " present"}, 0, 1);
    end else begin
      r = q4.pop_front();
      chk({nm, " period"}, r.p, ep);
      chk({nm, " ovf"}, r.o, eo);
    end
  endtask

  initial begin
    tbl[0] = '{20, 1'b0, 0, 1'b0, 0, 1'b0};
    tbl[1] = '{20, 1'b1, 20, 1'b0, 15, 1'b1};
    tbl[2] = '{20, 1'b1, 20, 1'b0, 15, 1'b1};
    tbl[3] = '{40, 1'b1, 20, 1'b0, 15, 1'b1};
    tbl[4] = '{8, 1'b1, 40, 1'b0, 15, 1'b1};
    tbl[5] = '{12, 1'b1, 8, 1'b0, 8, 1'b0};
    tbl[6] = '{12, 1'b1, 12, 1'b0, 12, 1'b0};

    clr   = 1'b1;
    t_in  = 1'b0;
    en    = 1'b1;
    ready = 1'b1;

    // reset overrides en and a toggling input
    for (int i = 0; i < 4; i++) begin
      t_in = ~t_in;
      step();
      chk("rst period", p16, 0);
      chk("rst valid", v16, 0);
      chk("rst ovf", o16, 0);
      chk("rst drop", d16, 0);
      chk("rst edges", e16, 0);
      chk("rst busy", b16, 0);
      chk("rst busy4", b4, 0);
    end
    clr  = 1'b0;
    t_in = 1'b0;
    step();
    step();
    chk("armed busy", b16, 1);

    // table: each row's rise closes the previous row's interval
    for (int i = 0; i < 7; i++) begin
      gap(tbl[i].sp);
      chk("tbl edges", e16, i + 1);
      chk("tbl edges4", e4, i + 1);
      chk("tbl busy", b16, 1);
      if (tbl[i].has) begin
        pop16("tbl r16", tbl[i].p16, tbl[i].o16);
        pop4("tbl r4", tbl[i].p4, tbl[i].o4);
      end else begin
        chk("tbl first no result", q16.size(), 0);
        chk("tbl first no result4", q4.size(), 0);
      end
    end

    // back-pressure: hold first result, drop second
    ready = 1'b0;
    gap(10);
    chk("hold valid", v16, 1);
    chk("hold period", p16, 12);
    chk("hold drop", d16, 0);
    gap(10);
    chk("drop valid", v16, 1);
    chk("drop period", p16, 12);
    chk("drop flag", d16, 1);
    ready = 1'b1;
    step();
    chk("accept valid", v16, 0);
    chk("accept drop sticky", d16, 1);
    pop16("accept r16", 12, 0);
    q4.delete();

    // ready asserted on the very cycle a new result loads
    clr = 1'b1;
    step();
    clr   = 1'b0;
    ready = 1'b0;
    chk("clr drop", d16, 0);
    chk("clr valid", v16, 0);
    step();
    gap(10);
    gap(14);
    chk("pre valid", v16, 1);
    chk("pre period", p16, 10);
    t_in = 1'b1;
    step();
    step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("swap valid", v16, 1);
    chk("swap period", p16, 14);
    chk("swap drop", d16, 0);
    pop16("swap r16", 10, 0);
    repeat (3) step();
    t_in = 1'b0;
    repeat (3) step();
    chk("swap stable", p16, 14);
    chk("swap stable v", v16, 1);

    // en drop mid-measure keeps pending result
    en = 1'b0;
    step();
    chk("en0 busy", b16, 0);
    chk("en0 valid", v16, 1);
    chk("en0 period", p16, 14);
    ready = 1'b1;
    step();
    chk("en0 drain", v16, 0);
    pop16("en0 r16", 14, 0);
    en = 1'b1;
    step();
    chk("re-arm busy", b16, 1);
    gap(10);
    chk("re-arm no result", q16.size(), 0);
    chk("re-arm valid", v16, 0);
    gap(16);
    pop16("re-arm r16", 10, 0);

    // clear with a result pending
    ready = 1'b0;
    gap(10);
    chk("pend valid", v16, 1);
    chk("pend period", p16, 16);
    clr = 1'b1;
    step();
    chk("mid clr valid", v16, 0);
    chk("mid clr busy", b16, 0);
    chk("mid clr period", p16, 0);
    chk("mid clr edges", e16, 0);
    clr = 1'b0;
    en  = 1'b0;
    step();
    q4.delete();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
